// File: rtl/load_data_unit.sv
// Memory-stage load path: one word-aligned read per load, then byte/half/word
// extraction with sign or zero extension. Misaligned, illegal and timed-out loads complete with an error.
module load_data_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_load_req,
  input  logic [31:0] i_addr,
  input  logic [2:0]  i_load_type,
  output logic        o_mem_rd,
  output logic [31:0] o_mem_addr,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_mem_ack,
  output logic [31:0] o_load_data,
  output logic        o_load_valid,
  output logic        o_load_err,
  output logic        o_busy,
  output logic [1:0]  o_dbg_state
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [1:0]    off_q, off_nxt;
  logic [2:0]    type_q, type_nxt;
  logic          err_q, err_nxt;
  logic          mem_rd_nxt;
  logic [31:0]   mem_addr_nxt;
  logic [31:0]   load_data_nxt;
  logic          load_valid_nxt;
  logic          load_err_nxt;
  logic          req_ok;
  logic          ack_seen;
  logic          timer_expired;

  function automatic logic load_ok(input logic [2:0] t, input logic [1:0] off);
    case (t)
      3'b000, 3'b100: load_ok = 1'b1;
      3'b001, 3'b101: load_ok = ~off[0];
      3'b011:         load_ok = (off == 2'b00);
      default:        load_ok = 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] format_load(input logic [2:0] t, input logic [1:0] off,
                                              input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    case (t)
      3'b000:  format_load = {{24{b[7]}}, b};
      3'b001:  format_load = {{16{h[15]}}, h};
      3'b100:  format_load = {24'b0, b};
      3'b101:  format_load = {16'b0, h};
      default: format_load = w;
    endcase
  endfunction

  // Memory handshake: o_mem_rd stays high with o_mem_addr stable until a cycle
  // in which i_mem_ack=1; that cycle transfers i_mem_rdata. Ack is ignored while o_mem_rd=0.
  assign req_ok        = load_ok(i_load_type, i_addr[1:0]);
  assign ack_seen      = o_mem_rd && i_mem_ack;
  assign timer_expired = (timer == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (i_load_req) state_nxt = req_ok ? S_REQ : S_DONE;
      S_REQ:   if (ack_seen || timer_expired) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    timer_nxt      = timer;
    off_nxt        = off_q;
    type_nxt       = type_q;
    err_nxt        = err_q;
    mem_rd_nxt     = o_mem_rd;
    mem_addr_nxt   = o_mem_addr;
    load_data_nxt  = o_load_data;
    load_valid_nxt = (state == S_DONE);
    load_err_nxt   = (state == S_DONE) && err_q;
    case (state)
      S_IDLE: begin
        if (i_load_req) begin
          off_nxt   = i_addr[1:0];
          type_nxt  = i_load_type;
          timer_nxt = '0;
          if (req_ok) begin
            mem_rd_nxt   = 1'b1;
            mem_addr_nxt = {i_addr[31:2], 2'b00};
            err_nxt      = 1'b0;
          end else begin
            err_nxt       = 1'b1;
            load_data_nxt = '0;
          end
        end
      end
      S_REQ: begin
        // An ack on the last allowed cycle still completes the load normally.
        if (ack_seen) begin
          mem_rd_nxt    = 1'b0;
          err_nxt       = 1'b0;
          load_data_nxt = format_load(type_q, off_q, i_mem_rdata);
        end else if (timer_expired) begin
          mem_rd_nxt    = 1'b0;
          err_nxt       = 1'b1;
          load_data_nxt = '0;
        end else begin
          timer_nxt = timer + TW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      timer        <= '0;
      off_q        <= '0;
      type_q       <= '0;
      err_q        <= 1'b0;
      o_mem_rd     <= 1'b0;
      o_mem_addr   <= '0;
      o_load_data  <= '0;
      o_load_valid <= 1'b0;
      o_load_err   <= 1'b0;
    end else begin
      timer        <= timer_nxt;
      off_q        <= off_nxt;
      type_q       <= type_nxt;
      err_q        <= err_nxt;
      o_mem_rd     <= mem_rd_nxt;
      o_mem_addr   <= mem_addr_nxt;
      o_load_data  <= load_data_nxt;
      o_load_valid <= load_valid_nxt;
      o_load_err   <= load_err_nxt;
    end
  end

  assign o_busy      = (state != S_IDLE);
  assign o_dbg_state = state;

endmodule

// File: doc/load_data_unit.md
# load_data_unit

Memory-stage load path of the MIPS pipeline: accepts a load request from the pipeline, performs one word-aligned read on the data-memory port with a request/acknowledge handshake, then extracts and sign- or zero-extends the addressed byte, halfword or word. It is the read-side counterpart of the store-data formatter. While a load is in flight it raises a busy flag used by the hazard unit to stall the pipeline. Misaligned addresses, illegal load types and memory timeouts complete with an error flag instead of data.

## Interface
- TIMEOUT_CYCLES, 16: cycles allowed in REQ without acknowledge before the unit aborts; must be ≥1.
- i_clk  in  1  single clock; rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_load_req  in  1  load request; sampled only in IDLE.
- i_addr  in  32  byte address of the load.
- i_load_type  in  3  000 LB, 001 LH, 011 LW, 100 LBU, 101 LHU; all other codes are illegal.
- o_mem_rd  out  1  data-memory read strobe, registered.
- o_mem_addr  out  32  {addr[31:2], 2'b00}, registered.
- i_mem_rdata  in  32  memory read word, valid when i_mem_ack=1.
- i_mem_ack  in  1  read acknowledge; ignored unless o_mem_rd=1.
- o_load_data  out  32  formatted load result, registered.
- o_load_valid  out  1  one-cycle completion pulse.
- o_load_err  out  1  asserted with o_load_valid when the load failed.
- o_busy  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, REQ, DONE.
- IDLE: when i_load_req=1, latch i_addr and i_load_type.
  - Legal and aligned: go to REQ and set o_mem_rd=1, o_mem_addr=aligned address.
  - Illegal type, LH/LHU with addr[0]=1, or LW with addr[1:0]≠0: go to DONE with error set, o_load_data=0, and no memory access.
- REQ: o_mem_rd is held high and o_mem_addr is held stable until ack.
  - On i_mem_ack=1: capture the formatted data, drop o_mem_rd, go to DONE.
  - If no ack arrives within TIMEOUT_CYCLES cycles: drop o_mem_rd, set error, set data=0, go to DONE.
  - If ack arrives on the timeout cycle, the ack wins.
- DONE: o_load_valid=1 for exactly one cycle, with o_load_err as decided. Next state is IDLE.
- Byte lanes are little-endian. Byte k is rdata[8k+7:8k] with k=addr[1:0]. Half h is rdata[16h+15:16h] with h=addr[1].
- Extension:
  - LB/LH replicate the sign bit of the selected field into the upper bits.
  - LBU/LHU zero-fill the upper bits.
  - LW passes the word through unchanged.
- o_load_data holds its last completed value between loads.
- i_load_req outside IDLE is ignored. The requester must hold or re-issue it.

## Timing
- Reset values: state=IDLE, o_mem_rd=0, o_mem_addr=0, o_load_data=0, o_load_valid=0, o_load_err=0, o_busy=0. The timeout counter is 0.
- Reset asserted mid-operation clears all state and outputs immediately, without waiting for a clock edge. Any in-flight memory read is abandoned and no completion pulse is produced.
- Minimum latency, with the request accepted at edge 0 and ack present in the first REQ cycle:
  - o_mem_rd high after edge 0.
  - o_load_valid high after edge 2.
- Each cycle of ack delay adds one cycle of latency.
- Error path for misaligned or illegal requests: o_load_valid/o_load_err high after edge 1, and o_mem_rd never asserts.
- Timeout path: o_mem_rd stays high for exactly TIMEOUT_CYCLES cycles, then the error completion follows on the next cycle.
- o_busy is high from the cycle after acceptance through the DONE cycle inclusive. A new request is accepted in the first IDLE cycle after DONE, giving back-to-back loads with no gap beyond DONE.
- The timeout counter resets on every entry to REQ.

## Test plan
- LB at addr 0x103, rdata 0x80FF_1234, ack in first REQ cycle:
  - o_mem_addr=0x100 and o_load_data=0xFFFF_FF80.
  - Valid asserts 2 cycles after the request, with err=0.
- LBU at 0x103 and LHU at 0x102 on the same word:
  - 0x0000_0080 and 0x0000_80FF respectively.
  - LH at 0x102 gives 0xFFFF_80FF.
- LW at 0x200, ack delayed 5 cycles, rdata 0xDEAD_BEEF:
  - o_mem_rd is high for 6 cycles and o_busy is high throughout.
  - Completion is 0xDEAD_BEEF, err=0, with latency 7.
- LH at 0x101, LW at 0x102, and type 010:
  - Each produces err=1 and data=0 one cycle after the request.
  - o_mem_rd stays 0.
- No ack with TIMEOUT_CYCLES=16:
  - o_mem_rd is high for 16 cycles, then a valid+err pulse with data=0.
  - A second run with ack arriving on the 16th cycle completes with err=0.
- Reset asserted asynchronously in the middle of REQ:
  - o_mem_rd, o_busy and o_load_valid go low immediately.
  - After release, a new LW completes normally.
